// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: on-chip RAM plus KBSR/KBDR/DSR/DDR device registers
// behind a level request / ready handshake with programmable wait states.
module lc3_mem_ctrl #(
    parameter int            DW          = 16,
    parameter int            AW          = 16,
    parameter int            DEPTH       = 28801,
    parameter int            WAIT_STATES = 0,
    parameter logic [AW-1:0] MMIO_BASE   = 'hFE00,
    parameter string         INIT_FILE   = ""
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Mem_En,
    input  logic          i_RW,
    input  logic [AW-1:0] i_Mar,
    input  logic [DW-1:0] i_Mdr,
    output logic [DW-1:0] o_Out,
    output logic          o_R,
    input  logic          i_Kbd_Valid,
    input  logic [DW-1:0] i_Kbd_Data,
    output logic          o_Ddr_Valid,
    output logic [DW-1:0] o_Ddr_Data,
    input  logic          i_Ddr_Ack,
    output logic          o_Irq,
    output logic [1:0]    o_Dbg_State
);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: i_Mem_En is a level held until o_R is seen; o_R then stays
    // high (with o_Out stable) until i_Mem_En drops, and one idle cycle follows.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] mar_q;
    logic [DW-1:0] mdr_q;
    logic          rw_q;
    logic          kb_rdy, kb_ie, ds_rdy, ds_ie;
    logic [DW-1:0] kbdr;
    logic [DW-1:0] ram [0:DEPTH-1];

    logic [AW-1:0] acc_addr, off;
    logic [DW-1:0] acc_data, rd_data, kbsr_val, dsr_val;
    logic          acc_rw, do_access, in_mmio;
    logic          sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_ram;
    logic          ack_fire, ddr_accept;

    // With no wait states the access happens on the accepting edge, so it
    // must use the live inputs rather than the not-yet-latched copies.
    always_comb begin
        if (state == S_IDLE) begin
            acc_addr = i_Mar;
            acc_data = i_Mdr;
            acc_rw   = i_RW;
        end else begin
            acc_addr = mar_q;
            acc_data = mdr_q;
            acc_rw   = rw_q;
        end
        do_access = i_Mem_En && (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                                 ((state == S_WAIT) && (cnt == 4'd0)));

        off      = acc_addr - MMIO_BASE;
        in_mmio  = (off[AW-1:3] == '0);
        sel_kbsr = in_mmio && (off[2:0] == 3'd0);
        sel_kbdr = in_mmio && (off[2:0] == 3'd2);
        sel_dsr  = in_mmio && (off[2:0] == 3'd4);
        sel_ddr  = in_mmio && (off[2:0] == 3'd6);
        sel_ram  = !in_mmio && (32'(acc_addr) < DEPTH);

        kbsr_val     = '0;
        kbsr_val[15] = kb_rdy;
        kbsr_val[14] = kb_ie;
        dsr_val      = '0;
        dsr_val[15]  = ds_rdy;
        dsr_val[14]  = ds_ie;

        rd_data = '0;
        if (sel_kbsr)      rd_data = kbsr_val;
        else if (sel_kbdr) rd_data = kbdr;
        else if (sel_dsr)  rd_data = dsr_val;
        else if (sel_ddr)  rd_data = o_Ddr_Data;
        else if (sel_ram)  rd_data = ram[acc_addr[RAM_AW-1:0]];

        ack_fire   = i_Ddr_Ack && o_Ddr_Valid;
        ddr_accept = ds_rdy || ack_fire;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            mar_q       <= '0;
            mdr_q       <= '0;
            rw_q        <= 1'b0;
            o_R         <= 1'b0;
            o_Out       <= '0;
            kb_rdy      <= 1'b0;
            kb_ie       <= 1'b0;
            kbdr        <= '0;
            ds_rdy      <= 1'b1;
            ds_ie       <= 1'b0;
            o_Ddr_Valid <= 1'b0;
            o_Ddr_Data  <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_Mem_En) begin
                    mar_q <= i_Mar;
                    mdr_q <= i_Mdr;
                    rw_q  <= i_RW;
                    if (WAIT_STATES == 0) begin
                        state <= S_DONE;
                        o_R   <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= 4'(WAIT_STATES - 1);
                    end
                end
                S_WAIT: begin
                    if (!i_Mem_En) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= S_DONE;
                        o_R   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: if (!i_Mem_En) begin
                    state <= S_IDLE;
                    o_R   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (do_access && !acc_rw) o_Out <= rd_data;

            // Ack first so a DDR write on the same edge sees the freed slot.
            if (ack_fire) begin
                o_Ddr_Valid <= 1'b0;
                ds_rdy      <= 1'b1;
            end
            if (do_access && acc_rw) begin
                if (sel_kbsr) kb_ie <= acc_data[14];
                if (sel_dsr)  ds_ie <= acc_data[14];
                if (sel_ddr && ddr_accept) begin
                    o_Ddr_Data  <= acc_data;
                    o_Ddr_Valid <= 1'b1;
                    ds_rdy      <= 1'b0;
                end
            end
            if (do_access && !acc_rw && sel_kbdr) kb_rdy <= 1'b0;
            if (i_Kbd_Valid) begin
                kbdr   <= i_Kbd_Data;
                kb_rdy <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst && do_access && acc_rw && sel_ram)
            ram[acc_addr[RAM_AW-1:0]] <= acc_data;
    end

    assign o_Irq       = (kb_rdy && kb_ie) || (ds_rdy && ds_ie);
    assign o_Dbg_State = state;

endmodule
